intr_ctrl: RTL

Interrupt and system-register controller for the single-cycle processor. Latches device interrupt requests, holds the system registers (PCS, IHA, IRA, IDN) accessed by RSR/WSR, and sequences entry to and exit from the handler by issuing one-cycle PC redirects to the fetch stage. Sits beside the main instruction decoder and consumes its sysWrEn/sysRead/sysRet decode outputs.

---
 rtl/intr_pkg.sv | 15 +
 rtl/intr_ctrl_if.sv | 14 +
 rtl/intr_pending.sv | 48 ++++
 rtl/intr_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared encodings for the interrupt / system-register controller.
package intr_pkg;
   localparam logic [1:0] SEL_PCS = 2'd0;
   localparam logic [1:0] SEL_IHA = 2'd1;
   localparam logic [1:0] SEL_IRA = 2'd2;
   localparam logic [1:0] SEL_IDN = 2'd3;

   localparam int PCS_IE  = 0;
   localparam int PCS_OIE = 1;

   // Wide enough for up to 16 sources.
   localparam int IDX_W = 4;

   typedef enum logic [1:0] {RUN, ENTER, HANDLER, EXIT} state_t;
endpackage

// File: rtl/intr_ctrl_if.sv
// System-register access bus between the instruction decoder and intr_ctrl.
interface intr_ctrl_if #(parameter int DBITS = 32);
   logic             sysWrEn;
   logic             sysRead;
   logic             sysRet;
   logic [1:0]       sysRegSel;
   logic [DBITS-1:0] sysWrData;
   logic [DBITS-1:0] sysRdData;

   modport master (output sysWrEn, sysRead, sysRet, sysRegSel, sysWrData,
                   input  sysRdData);
   modport slave  (input  sysWrEn, sysRead, sysRet, sysRegSel, sysWrData,
                   output sysRdData);
endinterface

// File: rtl/intr_pending.sv
// Pending-request tracking plus lowest-index priority encoder.
// INTR_EDGE_DETECT_EN selects a latched rising-edge pending register; otherwise pend follows irq.
module intr_pending import intr_pkg::*; #(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq,
   input  logic               clr,
   input  logic [IDX_W-1:0]   clrIdx,
   output logic               anyPend,
   output logic [IDX_W-1:0]   pendIdx
);
   logic [NUM_SRC-1:0] pend;

`ifdef INTR_EDGE_DETECT_EN
   logic [NUM_SRC-1:0] irqQ;

   // Clear beats a simultaneous new edge; that edge is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         irqQ <= '0;
         pend <= '0;
      end else begin
         irqQ <= irq;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (clr && clrIdx == IDX_W'(i))
               pend[i] <= 1'b0;
            else if (irq[i] && !irqQ[i])
               pend[i] <= 1'b1;
         end
      end
   end
`else
   assign pend = irq;

   logic unused_lvl;
   assign unused_lvl = ^{clk, reset, clr, clrIdx};
`endif

   assign anyPend = |pend;

   always_comb begin
      pendIdx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (pend[i]) pendIdx = IDX_W'(i);
   end
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt and system-register controller: PCS/IHA/IRA/IDN, handler entry/exit redirects.
// Optional INTR_EDGE_DETECT_EN (see intr_pending) enables latched edge-triggered requests.
module intr_ctrl import intr_pkg::*; #(
   parameter int NUM_SRC = 4,
   parameter int DBITS   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq,
   input  logic               instBoundary,
   input  logic [DBITS-1:0]   nextPc,
   intr_ctrl_if.slave         sys,
   output logic               redirect,
   output logic [DBITS-1:0]   redirectPc,
   output logic               inHandler
);
   state_t           state, stateNext;
   logic             ie, oie;
   logic [DBITS-1:0] iha, ira;
   logic [IDX_W-1:0] idn;
   logic             anyPend;
   logic [IDX_W-1:0] pendIdx;
   logic             take, ret, wr;
   logic [DBITS-1:0] rdData;

   intr_pending #(.NUM_SRC(NUM_SRC)) u_pend (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq),
      .clr     (take),
      .clrIdx  (pendIdx),
      .anyPend (anyPend),
      .pendIdx (pendIdx)
   );

   assign wr   = sys.sysWrEn & instBoundary;
   assign ret  = sys.sysRet & instBoundary & (state == RUN || state == HANDLER);
   // HANDLER is excluded so interrupts never nest, even with IE set by software.
   assign take = instBoundary & ie & anyPend & !sys.sysWrEn & !sys.sysRet & (state == RUN);

   always_comb begin
      stateNext = state;
      case (state)
         RUN:     if (ret) stateNext = EXIT;
                  else if (take) stateNext = ENTER;
         ENTER:   stateNext = HANDLER;
         HANDLER: if (ret) stateNext = EXIT;
         EXIT:    stateNext = RUN;
         default: stateNext = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         ie    <= 1'b0;
         oie   <= 1'b0;
         iha   <= '0;
         ira   <= '0;
         idn   <= '0;
      end else begin
         state <= stateNext;
         if (wr) begin
            case (sys.sysRegSel)
               SEL_PCS: begin
                  ie  <= sys.sysWrData[PCS_IE];
                  oie <= sys.sysWrData[PCS_OIE];
               end
               SEL_IHA: iha <= sys.sysWrData;
               SEL_IRA: ira <= sys.sysWrData;
               default: ;
            endcase
         end
         if (take) begin
            ira <= nextPc;
            idn <= pendIdx;
            oie <= ie;
            ie  <= 1'b0;
         end
         // Restoring IE consumes the saved copy so PCS reads back as plain IE afterwards.
         if (ret) begin
            ie  <= oie;
            oie <= 1'b0;
         end
      end
   end

   assign redirect   = (state == ENTER) || (state == EXIT);
   assign redirectPc = (state == ENTER) ? iha :
                       (state == EXIT)  ? ira : '0;
   assign inHandler  = (state == HANDLER);

   always_comb begin
      rdData = '0;
      if (sys.sysRead) begin
         case (sys.sysRegSel)
            SEL_PCS: rdData = DBITS'({oie, ie});
            SEL_IHA: rdData = iha;
            SEL_IRA: rdData = ira;
            SEL_IDN: rdData = DBITS'(idn);
            default: rdData = '0;
         endcase
      end
   end

   assign sys.sysRdData = rdData;
endmodule
